// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU and word-organised data memory.
// Checks alignment/range, does read-modify-write for sh/sb and extends loads.
module mem_access_ctrl #(
  parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  s_mux,
  input  logic [2:0]  l_mux,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        out_of_range,
  output logic        dm_wena,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] DATA_LIMIT = DATA_BASE + 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        we_q;
  logic [1:0]  s_mux_q;
  logic [2:0]  l_mux_q;

  logic        req_word, req_half, req_misalign, req_oor, accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  // Classify the incoming request; fault checks use the live address.
  always_comb begin
    req_word = 1'b0;
    req_half = 1'b0;
    if (we) begin
      req_word = (s_mux == 2'b00) || (s_mux == 2'b11);
      req_half = (s_mux == 2'b01);
    end else begin
      req_half = (l_mux == 3'b001) || (l_mux == 3'b010);
      req_word = !(req_half || (l_mux == 3'b011) || (l_mux == 3'b100));
    end
    req_misalign = req_word ? (addr[1:0] != 2'b00) : (req_half ? addr[0] : 1'b0);
    req_oor      = (addr < DATA_BASE) || (addr >= DATA_LIMIT);
    accept       = (state == IDLE) && req;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) begin
        if (req_misalign || req_oor)                              state_next = DONE;
        else if (we && ((s_mux == 2'b00) || (s_mux == 2'b11)))    state_next = WR;
        else                                                      state_next = RD;
      end
      RD:      state_next = we_q ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    dm_wena  = (state == WR) && !rst;
    dm_addr  = {addr_q[31:2], 2'b00};
    dm_wdata = wdata_q;
    case (s_mux_q)
      2'b01: dm_wdata = addr_q[1] ? {wdata_q[15:0], word_q[15:0]}
                                  : {word_q[31:16], wdata_q[15:0]};
      2'b10: begin
        dm_wdata = word_q;
        dm_wdata[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      default: dm_wdata = wdata_q;
    endcase
  end

  // Lane select and sign/zero extension of the word read in RD.
  always_comb begin
    load_byte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (l_mux_q)
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b010:  load_ext = {16'h0000, load_half};
      3'b011:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext = {24'h000000, load_byte};
      default: load_ext = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      s_mux_q      <= 2'b00;
      l_mux_q      <= 3'b000;
      rdata        <= '0;
      misalign     <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      if (accept) begin
        addr_q       <= addr;
        wdata_q      <= wdata;
        we_q         <= we;
        s_mux_q      <= s_mux;
        l_mux_q      <= l_mux;
        misalign     <= req_misalign;
        out_of_range <= req_oor;
      end
      if (state == RD) begin
        word_q <= dm_rdata;
        if (!we_q) rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, randomized ops against a
// byte-level memory model, and hand sequences for reset abort and busy req.
module tb_mem_access_ctrl;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [1:0]  s_mux;
  logic [2:0]  l_mux;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, out_of_range, dm_wena;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem     [0:DEPTH-1] = '{default: 32'h0};
  logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};
  logic [31:0] model_rdata;
  logic [31:0] mem_off;
  logic [10:0] mem_idx;
  logic        mem_hit;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  s_mux;
    logic [2:0]  l_mux;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_oor;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t table_v[$];

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .s_mux(s_mux), .l_mux(l_mux),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .out_of_range(out_of_range), .dm_wena(dm_wena),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Word memory behind the controller: combinational read, write on the edge.
  assign mem_off  = dm_addr - BASE;
  assign mem_hit  = mem_off < 32'(DEPTH * 4);
  assign mem_idx  = mem_off[12:2];
  assign dm_rdata = mem_hit ? mem[mem_idx] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (dm_wena && mem_hit) mem[mem_idx] <= dm_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference model: works on individual bytes and plain arithmetic.
  task automatic model_op(inout vec_t v);
    int          size, w;
    logic [31:0] a, val;
    longint      la;
    if (v.we) size = (v.s_mux == 2'b01) ? 2 : ((v.s_mux == 2'b10) ? 1 : 4);
    else if (v.l_mux == 3'd1 || v.l_mux == 3'd2) size = 2;
    else if (v.l_mux == 3'd3 || v.l_mux == 3'd4) size = 1;
    else size = 4;
    la = longint'(v.addr);
    v.exp_mis = (la % size) != 0;
    v.exp_oor = (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
    v.exp_wr  = 0;
    if (v.exp_mis || v.exp_oor) begin
      v.exp_lat = 1;
    end else if (v.we) begin
      for (int i = 0; i < size; i++) begin
        a = v.addr + 32'(i);
        w = int'((a - BASE) >> 2);
        ref_mem[w][8 * int'(a[1:0]) +: 8] = v.wdata[8 * i +: 8];
      end
      v.exp_lat = (size == 4) ? 2 : 3;
      v.exp_wr  = 1;
    end else begin
      val = 32'h0;
      for (int i = 0; i < size; i++) begin
        a = v.addr + 32'(i);
        w = int'((a - BASE) >> 2);
        val = val + (32'(ref_mem[w][8 * int'(a[1:0]) +: 8]) << (8 * i));
      end
      if (v.l_mux == 3'd1 && val >= 32'h8000) val = val - 32'h10000;
      if (v.l_mux == 3'd3 && val >= 32'h80)   val = val - 32'h100;
      model_rdata = val;
      v.exp_lat   = 2;
    end
    v.exp_rdata = model_rdata;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int   cycles, wr_pulses, w;
    logic got_done;
    @(negedge clk);
    req = 1'b1; we = v.we; s_mux = v.s_mux; l_mux = v.l_mux;
    addr = v.addr; wdata = v.wdata;
    cycles = 0; wr_pulses = 0; got_done = 1'b0;
    while (!got_done && cycles < 12) begin
      @(negedge clk);
      cycles++;
      if (dm_wena) wr_pulses++;
      if (done) got_done = 1'b1;
    end
    req = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(v.exp_lat));
    checkOutput({tag, "_misalign"}, {31'b0, misalign}, {31'b0, v.exp_mis});
    checkOutput({tag, "_oor"}, {31'b0, out_of_range}, {31'b0, v.exp_oor});
    checkOutput({tag, "_rdata"}, rdata, v.exp_rdata);
    checkOutput({tag, "_writes"}, 32'(wr_pulses), 32'(v.exp_wr));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'h0);
    checkOutput({tag, "_idle"}, {31'b0, busy}, 32'h0);
    if (v.exp_wr == 1) begin
      w = int'((v.addr - BASE) >> 2);
      checkOutput({tag, "_memword"}, mem[w], ref_mem[w]);
    end
  endtask

  function automatic vec_t mk(input logic v_we, input logic [1:0] v_s,
                              input logic [2:0] v_l, input logic [31:0] v_addr,
                              input logic [31:0] v_wdata, input logic [31:0] e_rd,
                              input logic e_mis, input logic e_oor,
                              input int e_lat, input int e_wr);
    vec_t v;
    v.we = v_we; v.s_mux = v_s; v.l_mux = v_l; v.addr = v_addr; v.wdata = v_wdata;
    v.exp_rdata = e_rd; v.exp_mis = e_mis; v.exp_oor = e_oor;
    v.exp_lat = e_lat; v.exp_wr = e_wr;
    return v;
  endfunction

  initial begin
    vec_t v, mv;
    logic any_done;
    int   wr_seen;

    rst = 1'b1; req = 1'b0; we = 1'b0; s_mux = 2'b00; l_mux = 3'b000;
    addr = 32'h0; wdata = 32'h0; model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_flags", {30'b0, misalign, out_of_range}, 32'h0);
    checkOutput("reset_wena", {31'b0, dm_wena}, 32'h0);
    checkOutput("reset_dm_addr", dm_addr, 32'h0);
    rst = 1'b0;

    //                 we    s      l       addr            wdata          rdata        mis   oor   lat wr
    table_v.push_back(mk(1, 2'b00, 3'b000, 32'h1001_0000, 32'h8899_AABB, 32'h0000_0000, 0, 0, 2, 1));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1001_0000, 32'h0,         32'h8899_AABB, 0, 0, 2, 0));
    table_v.push_back(mk(1, 2'b10, 3'b000, 32'h1001_0001, 32'h1234_5677, 32'h8899_AABB, 0, 0, 3, 1));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1001_0000, 32'h0,         32'h8899_77BB, 0, 0, 2, 0));
    table_v.push_back(mk(0, 2'b00, 3'b011, 32'h1001_0002, 32'h0,         32'hFFFF_FF99, 0, 0, 2, 0));
    table_v.push_back(mk(0, 2'b00, 3'b100, 32'h1001_0002, 32'h0,         32'h0000_0099, 0, 0, 2, 0));
    table_v.push_back(mk(0, 2'b00, 3'b001, 32'h1001_0002, 32'h0,         32'hFFFF_8899, 0, 0, 2, 0));
    table_v.push_back(mk(0, 2'b00, 3'b010, 32'h1001_0002, 32'h0,         32'h0000_8899, 0, 0, 2, 0));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1001_0002, 32'h0,         32'h0000_8899, 1, 0, 1, 0));
    table_v.push_back(mk(1, 2'b01, 3'b000, 32'h1001_0003, 32'hFFFF_FFFF, 32'h0000_8899, 1, 0, 1, 0));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1000_FFFC, 32'h0,         32'h0000_8899, 0, 1, 1, 0));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1001_2000, 32'h0,         32'h0000_8899, 0, 1, 1, 0));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1000_FFFE, 32'h0,         32'h0000_8899, 1, 1, 1, 0));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1001_1FFC, 32'h0,         32'h0000_0000, 0, 0, 2, 0));
    table_v.push_back(mk(0, 2'b00, 3'b000, 32'h1001_0000, 32'h0,         32'h8899_77BB, 0, 0, 2, 0));
    table_v.push_back(mk(1, 2'b11, 3'b000, 32'h1001_0008, 32'hCAFE_F00D, 32'h8899_77BB, 0, 0, 2, 1));
    table_v.push_back(mk(0, 2'b00, 3'b111, 32'h1001_0008, 32'h0,         32'hCAFE_F00D, 0, 0, 2, 0));

    foreach (table_v[i]) begin
      mv = table_v[i];
      model_op(mv);
      applyStimulus(table_v[i], $sformatf("vec%0d", i));
    end

    for (int n = 0; n < 40; n++) begin
      v.we    = 1'($urandom);
      v.s_mux = 2'($urandom);
      v.l_mux = 3'($urandom);
      v.wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       v.addr = BASE - 32'($urandom_range(1, 4));
        1:       v.addr = BASE + 32'h2000 + 32'($urandom_range(0, 7));
        2:       v.addr = BASE + 32'h1FFC + 32'($urandom_range(0, 3));
        default: v.addr = BASE + 32'($urandom_range(0, 63));
      endcase
      model_op(v);
      applyStimulus(v, $sformatf("rnd%0d", n));
    end

    // Reset during WR of a sub-word store aborts it without a write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; s_mux = 2'b01; addr = BASE + 32'h6; wdata = 32'hAAAA_5555;
    @(negedge clk);
    checkOutput("abort_busy_rd", {31'b0, busy}, 32'h1);
    @(negedge clk);
    checkOutput("abort_wena_wr", {31'b0, dm_wena}, 32'h1);
    rst = 1'b1; req = 1'b0;
    #1;
    checkOutput("abort_wena_gated", {31'b0, dm_wena}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    checkOutput("abort_idle", {31'b0, busy}, 32'h0);
    checkOutput("abort_rdata_clr", rdata, 32'h0);
    any_done = done;
    repeat (3) begin
      @(negedge clk);
      any_done = any_done | done;
    end
    checkOutput("abort_no_done", {31'b0, any_done}, 32'h0);
    checkOutput("abort_mem", mem[1], ref_mem[1]);
    v = mk(0, 2'b00, 3'b000, BASE + 32'h4, 32'h0, 32'h0, 0, 0, 0, 0);
    model_op(v);
    applyStimulus(v, "abort_reload");

    // A req pulse while busy is neither executed nor queued.
    @(negedge clk);
    req = 1'b1; we = 1'b0; l_mux = 3'b000; addr = BASE;
    wr_seen = 0;
    @(negedge clk);
    checkOutput("busyreq_busy", {31'b0, busy}, 32'h1);
    we = 1'b1; s_mux = 2'b00; addr = BASE + 32'h8; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req = 1'b0;
    if (dm_wena) wr_seen++;
    checkOutput("busyreq_done", {31'b0, done}, 32'h1);
    checkOutput("busyreq_rdata", rdata, ref_mem[0]);
    repeat (3) begin
      @(negedge clk);
      if (dm_wena) wr_seen++;
      checkOutput("busyreq_stays_idle", {31'b0, busy}, 32'h0);
    end
    checkOutput("busyreq_no_write", 32'(wr_seen), 32'h0);
    checkOutput("busyreq_mem", mem[2], ref_mem[2]);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
